adc_agc_qnt: RTL and testbench

ADC_AGC_QNT -- requirements
Module: adc_agc_qnt

---
 rtl/adc_agc_qnt_pkg.sv | 25 ++
 rtl/adc_agc_qnt_abs_sat.sv | 22 ++
 rtl/adc_agc_qnt.sv | 160 ++++++++++++++++
 tb/tb_adc_agc_qnt.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_agc_qnt_pkg.sv
// Shared definitions for the ADC AGC quantizer: FSM encodings, band classes
// and the log2 helper used to size derived counters.
package adc_agc_qnt_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACQ   = 2'd1;
    localparam logic [1:0] ST_TRACK = 2'd2;

    typedef enum logic [1:0] {
        BAND_IN   = 2'd0,
        BAND_HIGH = 2'd1,
        BAND_LOW  = 2'd2
    } band_e;

    // Ceiling log2, used for widths that must hold values up to (and including) v-1.
    function automatic int log2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/adc_agc_qnt_abs_sat.sv
// Combinational saturating absolute value: the most-negative input maps to
// the largest positive magnitude instead of wrapping.
module abs_sat #(
    parameter int width = 14
) (
    input  logic signed [width-1:0] x,
    output logic        [width-2:0] y
);

    logic [width-1:0] neg_x;

    assign neg_x = -x;

    // Negating the most-negative value gives it back unchanged; its MSB flags saturation.
    always_comb begin
        y = x[width-2:0];
        if (x[width-1]) begin
            y = neg_x[width-1] ? '1 : neg_x[width-2:0];
        end
    end

endmodule

// File: rtl/adc_agc_qnt.sv
// 2-bit sign/magnitude quantizer whose magnitude threshold is steered so that
// about TARGET of every 2^WIN_LOG2 valid samples exceed it.
module adc_agc_qnt
    import adc_agc_qnt_pkg::*;
#(
    parameter int width       = 14,
    parameter int WIN_LOG2    = 10,
    parameter int TARGET      = 332,
    parameter int HYST        = 16,
    parameter int THR_INIT    = 256,
    parameter int COARSE_STEP = 64,
    parameter int LOCK_N      = 4
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic signed [width-1:0] data_in,
    input  logic                    valid_in,
    output logic [1:0]              data_out,
    output logic                    valid_out,
    output logic [width-2:0]        thr_out,
    output logic                    lock
);

    localparam int THR_W   = width - 1;
    localparam int CNT_W   = WIN_LOG2 + 1;
    localparam int GOOD_W  = log2(LOCK_N + 1);
    localparam int THR_MAX = (1 << THR_W) - 1;

    logic [THR_W-1:0]    abs_x;
    logic [THR_W-1:0]    thr;
    logic [THR_W-1:0]    thr_nxt;
    logic [WIN_LOG2-1:0] sample_cnt;
    logic [CNT_W-1:0]    hit_cnt;
    logic [CNT_W-1:0]    hit_total;
    logic [1:0]          state;
    logic [1:0]          state_nxt;
    logic [GOOD_W-1:0]   good_cnt;
    logic [GOOD_W-1:0]   good_nxt;
    logic                dir_valid;
    logic                dir_up;
    logic                dir_valid_nxt;
    logic                dir_up_nxt;
    logic                s1_valid;
    logic                s1_sign;
    logic                s1_mag;
    logic                s1_last;
    band_e               band;
    logic                far;
    int                  cnt;
    int                  step;
    int                  thr_calc;

    abs_sat #(.width(width)) u_abs_sat (
        .x (data_in),
        .y (abs_x)
    );

    assign thr_out   = thr;
    assign hit_total = hit_cnt + CNT_W'(s1_mag);

    // Two-stage pipeline; s1_last marks the final sample of a window one cycle before evaluation.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1_valid   <= 1'b0;
            s1_sign    <= 1'b0;
            s1_mag     <= 1'b0;
            s1_last    <= 1'b0;
            sample_cnt <= '0;
            valid_out  <= 1'b0;
            data_out   <= 2'b00;
        end else begin
            s1_valid  <= valid_in;
            s1_sign   <= valid_in && data_in[width-1];
            s1_mag    <= valid_in && (abs_x >= thr);
            s1_last   <= valid_in && (sample_cnt == '1);
            valid_out <= s1_valid;
            data_out  <= {s1_sign, s1_mag};
            if (valid_in) sample_cnt <= sample_cnt + 1'b1;
        end
    end

    // Window-end decision: classify the hit count and pick the next state and threshold step.
    always_comb begin
        cnt           = 32'(hit_total);
        band          = BAND_IN;
        far           = (cnt > TARGET + 4 * HYST) || (cnt < TARGET - 4 * HYST);
        step          = 0;
        state_nxt     = state;
        good_nxt      = good_cnt;
        dir_valid_nxt = dir_valid;
        dir_up_nxt    = dir_up;
        if (cnt > TARGET + HYST)      band = BAND_HIGH;
        else if (cnt < TARGET - HYST) band = BAND_LOW;

        case (state)
            ST_ACQ: begin
                if (band == BAND_IN) begin
                    state_nxt = ST_TRACK;
                    good_nxt  = GOOD_W'(1);
                end else if (dir_valid && (dir_up != (band == BAND_HIGH))) begin
                    step      = (band == BAND_HIGH) ? 1 : -1;
                    state_nxt = ST_TRACK;
                    good_nxt  = '0;
                end else begin
                    step          = (band == BAND_HIGH) ? COARSE_STEP : -COARSE_STEP;
                    dir_valid_nxt = 1'b1;
                    dir_up_nxt    = (band == BAND_HIGH);
                end
            end
            ST_TRACK: begin
                // Falling far out of band re-acquires with a coarse step and a fresh direction history.
                if (far) begin
                    step          = (band == BAND_HIGH) ? COARSE_STEP : -COARSE_STEP;
                    state_nxt     = ST_ACQ;
                    good_nxt      = '0;
                    dir_valid_nxt = 1'b0;
                    dir_up_nxt    = 1'b0;
                end else if (band == BAND_IN) begin
                    if (good_cnt < GOOD_W'(LOCK_N)) good_nxt = good_cnt + 1'b1;
                end else begin
                    step     = (band == BAND_HIGH) ? 1 : -1;
                    good_nxt = '0;
                end
            end
            default: ;
        endcase

        thr_calc = int'(thr) + step;
        if (thr_calc < 1)            thr_calc = 1;
        else if (thr_calc > THR_MAX) thr_calc = THR_MAX;
        thr_nxt = THR_W'(thr_calc);
    end

    // Control state only moves on valid traffic or on the evaluation cycle after a window's last sample.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= ST_IDLE;
            thr       <= THR_W'(THR_INIT);
            hit_cnt   <= '0;
            good_cnt  <= '0;
            dir_valid <= 1'b0;
            dir_up    <= 1'b0;
            lock      <= 1'b0;
        end else begin
            lock <= (state == ST_TRACK) && (good_cnt == GOOD_W'(LOCK_N));
            if (s1_last) begin
                state     <= state_nxt;
                thr       <= thr_nxt;
                good_cnt  <= good_nxt;
                dir_valid <= dir_valid_nxt;
                dir_up    <= dir_up_nxt;
                hit_cnt   <= '0;
            end else begin
                if (state == ST_IDLE && valid_in) state <= ST_ACQ;
                if (s1_mag) hit_cnt <= hit_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_adc_agc_qnt.sv
// Bench for adc_agc_qnt: directed vector table, hand-written window sequences
// and randomized traffic compared against a sample-level reference model.
module tb_adc_agc_qnt;

    localparam int WIN     = 1024;
    localparam int TARGET  = 332;
    localparam int HYST    = 16;
    localparam int COARSE  = 64;
    localparam int LOCK_N  = 4;
    localparam int THR_MAX = 8191;

    logic               clk;
    logic               resetn;
    logic signed [13:0] data_in;
    logic               valid_in;
    logic [1:0]         data_out;
    logic               valid_out;
    logic [12:0]        thr_out;
    logic               lock;

    int checks = 0;
    int errors = 0;

    adc_agc_qnt dut (
        .clk       (clk),
        .resetn    (resetn),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .data_out  (data_out),
        .valid_out (valid_out),
        .thr_out   (thr_out),
        .lock      (lock)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     name, actual, actual, expected, expected, $time);
        end
    endtask

    // Reference model: works per sample and per window; mode 0=idle, 1=acq, 2=track.
    int         m_mode, m_good, m_last_dir, m_samples, m_hits, pend_hits, m_abs;
    bit         pend, m_mag;
    int         e_thr;
    bit         e_lock, e_v1, e_vo;
    logic [1:0] e_d1, e_do;
    bit         model_chk = 1'b0;

    task automatic model_reset();
        m_mode = 0; m_good = 0; m_last_dir = 0; m_samples = 0; m_hits = 0;
        pend = 1'b0; pend_hits = 0; e_thr = 256; e_lock = 1'b0;
        e_v1 = 1'b0; e_vo = 1'b0; e_d1 = 2'b00; e_do = 2'b00;
    endtask

    task automatic bump(input int delta);
        e_thr = e_thr + delta;
        if (e_thr < 1) e_thr = 1;
        if (e_thr > THR_MAX) e_thr = THR_MAX;
    endtask

    task automatic model_eval(input int hits);
        int dir, dev;
        dir = (hits > TARGET + HYST) ? 1 : (hits < TARGET - HYST) ? -1 : 0;
        dev = (hits > TARGET) ? hits - TARGET : TARGET - hits;
        if (m_mode == 1) begin
            if (dir == 0) begin
                m_mode = 2; m_good = 1;
            end else if (m_last_dir == -dir) begin
                bump(dir); m_mode = 2; m_good = 0;
            end else begin
                bump(dir * COARSE); m_last_dir = dir;
            end
        end else if (m_mode == 2) begin
            if (dev > 4 * HYST) begin
                bump(dir * COARSE); m_mode = 1; m_good = 0; m_last_dir = 0;
            end else if (dir == 0) begin
                if (m_good < LOCK_N) m_good++;
            end else begin
                bump(dir); m_good = 0;
            end
        end
    endtask

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            model_reset();
        end else begin
            e_vo   = e_v1;
            e_do   = e_d1;
            e_lock = (m_mode == 2) && (m_good == LOCK_N);
            m_mag  = 1'b0;
            if (valid_in) begin
                m_abs = (int'(data_in) < 0) ? -int'(data_in) : int'(data_in);
                if (m_abs > THR_MAX) m_abs = THR_MAX;
                m_mag = (m_abs >= e_thr);
                e_v1  = 1'b1;
                e_d1  = {(data_in < 0), m_mag};
            end else begin
                e_v1 = 1'b0;
                e_d1 = 2'b00;
            end
            if (pend) begin
                pend = 1'b0;
                model_eval(pend_hits);
            end
            if (valid_in) begin
                if (m_mode == 0) m_mode = 1;
                m_samples++;
                if (m_mag) m_hits++;
                if (m_samples == WIN) begin
                    pend = 1'b1; pend_hits = m_hits; m_hits = 0; m_samples = 0;
                end
            end
        end
    end

    logic [16:0] act_w, exp_w;
    always @(negedge clk) begin
        if (model_chk) begin
            act_w = {lock, thr_out, valid_out, data_out};
            exp_w = {e_lock, 13'(e_thr), e_vo, e_do};
            check_output("model_outputs", int'(act_w), int'(exp_w));
        end
    end

    // kind: 0 const +1000, 1 in-band pattern, 2 all +-100, 3 random of amplitude amp, 4 +1000 with valid toggling
    task automatic apply_stimulus(input int n, input int kind, input int amp);
        int x;
        bit v;
        for (int j = 0; j < n; j++) begin
            v = 1'b1;
            x = 1000;
            case (kind)
                1: x = (((j % WIN) < TARGET) ? 500 : 100) * (((j % 2) == 1) ? -1 : 1);
                2: x = ((j % 2) == 1) ? -100 : 100;
                3: begin
                    v = ($urandom_range(0, 9) < 8);
                    x = int'($urandom_range(0, 2 * amp)) - amp;
                end
                4: v = ((j % 2) == 0);
                default: ;
            endcase
            @(negedge clk);
            valid_in = v;
            data_in  = 14'(x);
        end
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) begin
            @(negedge clk);
            valid_in = 1'b0;
            data_in  = '0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        valid_in = 1'b0;
        data_in  = '0;
        #2 resetn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    typedef struct {
        int         data;
        bit         valid;
        logic [1:0] exp_data;
        bit         exp_valid;
    } vec_t;

    vec_t vecs[12];
    int   amps[8] = '{400, 300, 1500, 350, 8192, 250, 500, 380};

    initial begin
        resetn   = 1'b1;
        valid_in = 1'b0;
        data_in  = '0;
        #2 resetn = 1'b0;
        #1;
        check_output("reset_data_out", int'(data_out), 0);
        check_output("reset_valid_out", int'(valid_out), 0);
        check_output("reset_thr_out", int'(thr_out), 256);
        check_output("reset_lock", int'(lock), 0);
        @(negedge clk);
        @(negedge clk);
        resetn    = 1'b1;
        model_chk = 1'b1;

        // Quantizer table at the reset threshold of 256.
        vecs[0]  = '{1000,  1'b1, 2'b01, 1'b1};
        vecs[1]  = '{-1000, 1'b1, 2'b11, 1'b1};
        vecs[2]  = '{255,   1'b1, 2'b00, 1'b1};
        vecs[3]  = '{256,   1'b1, 2'b01, 1'b1};
        vecs[4]  = '{-256,  1'b1, 2'b11, 1'b1};
        vecs[5]  = '{-255,  1'b1, 2'b10, 1'b1};
        vecs[6]  = '{-8192, 1'b1, 2'b11, 1'b1};
        vecs[7]  = '{8191,  1'b1, 2'b01, 1'b1};
        vecs[8]  = '{0,     1'b1, 2'b00, 1'b1};
        vecs[9]  = '{-1,    1'b1, 2'b10, 1'b1};
        vecs[10] = '{500,   1'b0, 2'b00, 1'b0};
        vecs[11] = '{-8192, 1'b0, 2'b00, 1'b0};
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                check_output($sformatf("vec%0d_data_out", i - 2), int'(data_out), int'(vecs[i-2].exp_data));
                check_output($sformatf("vec%0d_valid_out", i - 2), int'(valid_out), int'(vecs[i-2].exp_valid));
            end
            if (i < 12) begin
                valid_in = vecs[i].valid;
                data_in  = 14'(vecs[i].data);
            end else begin
                valid_in = 1'b0;
                data_in  = '0;
            end
        end

        // Constant +1000: two coarse upward steps while acquiring.
        do_reset();
        apply_stimulus(WIN, 0, 0);
        idle(3);
        check_output("const_win1_thr", int'(thr_out), 320);
        check_output("const_win1_lock", int'(lock), 0);
        apply_stimulus(WIN, 0, 0);
        idle(3);
        check_output("const_win2_thr", int'(thr_out), 384);

        // In-band pattern locks after four windows, then a quiet input knocks it back to acquisition.
        do_reset();
        apply_stimulus(3 * WIN, 1, 0);
        idle(3);
        check_output("band_w3_lock", int'(lock), 0);
        apply_stimulus(WIN, 1, 0);
        @(negedge clk);
        valid_in = 1'b0;
        @(posedge clk);
        #1;
        check_output("band_eval_lock", int'(lock), 0);
        check_output("band_eval_thr", int'(thr_out), 256);
        @(posedge clk);
        #1;
        check_output("band_lock_rise", int'(lock), 1);
        apply_stimulus(WIN, 2, 0);
        @(negedge clk);
        valid_in = 1'b0;
        @(posedge clk);
        #1;
        check_output("quiet_eval_thr", int'(thr_out), 192);
        check_output("quiet_eval_lock", int'(lock), 1);
        @(posedge clk);
        #1;
        check_output("quiet_lock_drop", int'(lock), 0);

        // Valid toggling: the window is counted in valid samples, not cycles.
        do_reset();
        apply_stimulus(2046, 4, 0);
        idle(3);
        check_output("toggle_1023_thr", int'(thr_out), 256);
        apply_stimulus(2, 4, 0);
        idle(3);
        check_output("toggle_1024_thr", int'(thr_out), 320);

        // Reset in the middle of a window discards its partial statistics.
        do_reset();
        apply_stimulus(WIN + 500, 0, 0);
        #2 resetn = 1'b0;
        #1;
        check_output("midreset_data_out", int'(data_out), 0);
        check_output("midreset_valid_out", int'(valid_out), 0);
        check_output("midreset_thr", int'(thr_out), 256);
        check_output("midreset_lock", int'(lock), 0);
        @(negedge clk);
        valid_in = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        apply_stimulus(WIN - 1, 0, 0);
        idle(3);
        check_output("resume_1023_thr", int'(thr_out), 256);
        apply_stimulus(1, 0, 0);
        idle(3);
        check_output("resume_1024_thr", int'(thr_out), 320);

        // Randomized traffic with varying amplitude per block, checked by the model every cycle.
        do_reset();
        for (int b = 0; b < 8; b++) begin
            apply_stimulus(WIN, 3, amps[b]);
        end
        idle(4);

        model_chk = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
